vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Raster scan generator for the VGA output path. It produces the pixel `enable` qualifier, the HSYNC/VSYNC strobes and the frame-buffer read requests. The `enable` qualifier is the signal that the RGB gating stage consumes. Each read address is issued `RD_LATENCY` cycles ahead of its display slot, so returned `DATA_IN` arrives at the RGB stage in the same cycle as the matching `enable`. The block runs in the pixel clock domain and sits between the thermogram frame buffer and the RGB gating stage.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porches and sync width, in clocks
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porches and sync width, in lines
- SYNC_POL, 0: active level of HSYNC/VSYNC (0 = active-low)
- RD_LATENCY, 2: frame-buffer read latency in clocks, range 1..4
- ADDR_W, 19: read address width

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: pixel clock (25 MHz for the defaults)
- reset, input, 1: asynchronous, active-high
- run, input, 1: scan enable
- RD_REQ, output, 1: frame-buffer read strobe
- RD_ADDR, output, ADDR_W: linear pixel address, equal to y*H_ACTIVE + x
- enable, output, 1: active-video qualifier, aligned with returned DATA_IN
- HSYNC, output, 1: horizontal sync
- VSYNC, output, 1: vertical sync
- FRAME_START, output, 1: one-clock pulse aligned with the first `enable` of each frame
- BUSY, output, 1: high in RUN and STOP_PEND

## Operation
- Counters:
  - h_cnt runs 0..H_TOT-1, where H_TOT = sum of the H parameters (800 for the defaults).
  - v_cnt runs 0..V_TOT-1 (525 for the defaults); it increments when h_cnt wraps and wraps itself at V_TOT-1.
- Stage-0 decode:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- RD_REQ and RD_ADDR:
  - RD_REQ = act, registered one cycle after the counters.
  - RD_ADDR is an incrementing counter, not a multiplier.
  - It advances by one after each request and returns to 0 at frame start (h=0, v=0).
- Delay line: act, hs, vs and the frame-start flag pass through a RD_LATENCY-deep delay line to drive enable, HSYNC, VSYNC and FRAME_START.
  - Sync outputs drive SYNC_POL when asserted and ~SYNC_POL otherwise.
- State machine:
  - IDLE: counters held at 0; RD_REQ=0; delay-line inputs forced inactive. Goes to RUN when run=1.
  - RUN: counters free-run. Goes to STOP_PEND when run=0.
  - STOP_PEND: keeps scanning. Returns to RUN if run=1 again, with no glitch and no counter reset. Goes to IDLE in the cycle after h_cnt=H_TOT-1 and v_cnt=V_TOT-1.
- Stops therefore only happen on frame boundaries, and a partial frame is never emitted.
- After IDLE, the delay line drains inactive values, so the outputs settle to idle levels within RD_LATENCY cycles.

## Timing
- Reset values: enable=0, RD_REQ=0, RD_ADDR=0, FRAME_START=0, BUSY=0, HSYNC=VSYNC=~SYNC_POL; state IDLE; counters 0; delay line cleared to inactive.
- Start-up:
  - run sampled high in cycle n: state is RUN at n+1, and h_cnt=0, v_cnt=0 in cycle n+1.
  - RD_REQ with RD_ADDR=0 appears at n+2.
  - enable and FRAME_START appear at n+2+RD_LATENCY.
- Alignment: RD_REQ at cycle t corresponds to DATA_IN and enable at cycle t+RD_LATENCY.
- Per frame:
  - 640 consecutive enable cycles per line.
  - 160 blanking cycles between lines.
  - 480 active lines, then 45 blank lines.
  - 307200 requests, with final RD_ADDR = 307199.
- HSYNC position: HSYNC asserts 16 clocks after the last enable of a line and lasts 96 clocks.
- VSYNC position: VSYNC covers lines 490–491, i.e. 1600 clocks, and is asserted as a line-aligned level.
- run toggling while the counters are at the last pixel of a frame: run=0 sampled in that same cycle means the next frame does not start.
- Asynchronous reset mid-line: all outputs go to their reset values immediately, with no pending pulses.

## Test plan
- Reset, then run=1 held for 2 frames:
  - Count 307200 enable cycles per frame and 525 HSYNC pulses per frame.
  - Exactly 1 FRAME_START per frame, coincident with the first enable.
- Alignment check: model the frame buffer as returning DATA_IN = RD_ADDR after RD_LATENCY cycles. Sweep RD_LATENCY over 1, 2 and 4.
  - Every enable cycle must see DATA_IN equal to the expected y*640+x.
- Sync geometry: measure from the last enable of line 0.
  - HSYNC goes low after 16 clocks and stays low for 96 clocks.
  - VSYNC is low for exactly 1600 clocks, starting 10 lines after the last active line.
- Stop and restart: deassert run at line 100 of a frame.
  - The frame completes with 307200 enables, then BUSY=0 and all outputs idle.
  - Reassert run: RD_ADDR restarts at 0.
- Cancelled stop: deassert run for 5 cycles at line 200, then reassert it.
  - Scan continues with no counter discontinuity.
  - RD_ADDR stays monotonic through the frame.
- Asynchronous reset at h=300, v=50: within the same cycle enable=0, RD_REQ=0 and HSYNC=VSYNC=1 (default polarity). With run still high, the first FRAME_START arrives 2+RD_LATENCY cycles after reset release.

Source files
------------

// File: rtl/vga_scan_gen.sv
// Raster scan generator: free-running h/v counters, frame-buffer read requests
// issued RD_LATENCY clocks ahead of display, and a matching delay line that
// realigns enable/HSYNC/VSYNC/FRAME_START with the returned pixel data.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | counters parked at 0, no requests, delay line fed inactive
// S_RUN     | counters free-run, one request per visible pixel
// S_STOP_PEND | run dropped; finish the current frame, then go idle
module vga_scan_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              RD_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic              enable,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              FRAME_START,
    output logic              BUSY
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("vga_scan_gen: RD_LATENCY must be within 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            last_pix;
    logic            scanning;
    logic            act0;
    logic            hs0;
    logic            vs0;
    logic            fs0;
    logic            hs1;
    logic            vs1;
    logic            fs1;
    logic            hs_d;
    logic            vs_d;
    logic [3:0]      dly [RD_LATENCY];

    assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign scanning = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A run drop seen on the last pixel of a frame goes
    // straight to idle so that no further frame is started.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!run) state_nxt = last_pix ? S_IDLE : S_STOP_PEND;
            end
            S_STOP_PEND: begin
                if (run)           state_nxt = S_RUN;
                else if (last_pix) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Horizontal/vertical counters; parked at the frame origin while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == S_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign act0 = scanning && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs0  = scanning && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    assign vs0  = scanning && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    assign fs0  = scanning && (h_cnt == '0) && (v_cnt == '0);

    // Request stage: address is a running count of issued requests,
    // reloaded to 0 on the first pixel of every frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RD_REQ  <= 1'b0;
            RD_ADDR <= '0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            fs1     <= 1'b0;
        end else begin
            RD_REQ <= act0;
            hs1    <= hs0;
            vs1    <= vs0;
            fs1    <= fs0;
            if (state == S_IDLE) begin
                RD_ADDR <= '0;
            end else if (act0) begin
                RD_ADDR <= fs0 ? '0 : RD_ADDR + ADDR_W'(1);
            end
        end
    end

    // Delay line matching the frame-buffer read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= {RD_REQ, hs1, vs1, fs1};
            for (int i = 1; i < RD_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign {enable, hs_d, vs_d, FRAME_START} = dly[RD_LATENCY-1];
    assign HSYNC = hs_d ? SYNC_POL : ~SYNC_POL;
    assign VSYNC = vs_d ? SYNC_POL : ~SYNC_POL;
    assign BUSY  = scanning;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen using a reduced 16x10 raster (8x6 visible) so whole
// frames fit in a few hundred clocks. Three instances cover RD_LATENCY 1, 2, 4.
module tb_vga_scan_gen;

    localparam int HT = 16;
    localparam int VT = 10;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic reset;
    logic run;

    logic [2:0]      rd_req;
    logic [2:0][7:0] rd_addr;
    logic [2:0]      en;
    logic [2:0]      hsync;
    logic [2:0]      vsync;
    logic [2:0]      fs;
    logic [2:0]      busy;

    logic [7:0] fbq [3][4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .RD_LATENCY(1), .ADDR_W(8)) u_lat1 (
        .clk(clk), .reset(reset), .run(run), .RD_REQ(rd_req[0]), .RD_ADDR(rd_addr[0]),
        .enable(en[0]), .HSYNC(hsync[0]), .VSYNC(vsync[0]), .FRAME_START(fs[0]), .BUSY(busy[0]));

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .RD_LATENCY(2), .ADDR_W(8)) u_lat2 (
        .clk(clk), .reset(reset), .run(run), .RD_REQ(rd_req[1]), .RD_ADDR(rd_addr[1]),
        .enable(en[1]), .HSYNC(hsync[1]), .VSYNC(vsync[1]), .FRAME_START(fs[1]), .BUSY(busy[1]));

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .RD_LATENCY(4), .ADDR_W(8)) u_lat4 (
        .clk(clk), .reset(reset), .run(run), .RD_REQ(rd_req[2]), .RD_ADDR(rd_addr[2]),
        .enable(en[2]), .HSYNC(hsync[2]), .VSYNC(vsync[2]), .FRAME_START(fs[2]), .BUSY(busy[2]));

    // Frame-buffer model: data returned is the address, delayed per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            fbq[i][0] <= rd_addr[i];
            for (int k = 1; k < 4; k++) fbq[i][k] <= fbq[i][k-1];
        end
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    // Raster model indexed by scan position p (p < 0: not yet scanning).
    function automatic bit m_act(input int p);
        if (p < 0) return 1'b0;
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic bit m_hs(input int p);
        if (p < 0) return 1'b0;
        return ((p % HT) >= 10) && ((p % HT) <= 12);
    endfunction

    function automatic bit m_vs(input int p);
        if (p < 0) return 1'b0;
        return (((p / HT) % VT) >= 7) && (((p / HT) % VT) <= 8);
    endfunction

    function automatic bit m_fs(input int p);
        return (p >= 0) && ((p % FT) == 0);
    endfunction

    function automatic int m_addr(input int p);
        return ((p / HT) % VT) * HA + (p % HT);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        run   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        run   = 1'b0;
        reset = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (en[i] !== 1'b0)      begin n_fail++; $display("FAIL reset enable inst%0d: got %b exp 0", i, en[i]); end
            n_checks++; if (rd_req[i] !== 1'b0)  begin n_fail++; $display("FAIL reset rd_req inst%0d: got %b exp 0", i, rd_req[i]); end
            n_checks++; if (rd_addr[i] !== 8'd0) begin n_fail++; $display("FAIL reset rd_addr inst%0d: got %0d exp 0", i, rd_addr[i]); end
            n_checks++; if (fs[i] !== 1'b0)      begin n_fail++; $display("FAIL reset frame_start inst%0d: got %b exp 0", i, fs[i]); end
            n_checks++; if (busy[i] !== 1'b0)    begin n_fail++; $display("FAIL reset busy inst%0d: got %b exp 0", i, busy[i]); end
            n_checks++; if (hsync[i] !== 1'b1)   begin n_fail++; $display("FAIL reset hsync inst%0d: got %b exp 1", i, hsync[i]); end
            n_checks++; if (vsync[i] !== 1'b1)   begin n_fail++; $display("FAIL reset vsync inst%0d: got %b exp 1", i, vsync[i]); end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Two full frames, cycle-exact against the raster model, plus data alignment.
    task automatic test_frames();
        int n_en [3];
        int n_fs [3];
        int n_hs [3];
        logic prev_hs [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin n_en[i] = 0; n_fs[i] = 0; n_hs[i] = 0; prev_hs[i] = 1'b1; end
        run = 1'b1;
        for (int j = 0; j <= 2 * FT + 6; j++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                int L  = lat_of(i);
                int pr = j - 1;
                int pe = j - 1 - L;
                n_checks++; if (rd_req[i] !== m_act(pr)) begin n_fail++; $display("FAIL frames rd_req lat%0d cyc%0d: got %b exp %b", L, j, rd_req[i], m_act(pr)); end
                if (m_act(pr)) begin
                    n_checks++; if (rd_addr[i] !== 8'(m_addr(pr))) begin n_fail++; $display("FAIL frames rd_addr lat%0d cyc%0d: got %0d exp %0d", L, j, rd_addr[i], m_addr(pr)); end
                end
                n_checks++; if (en[i] !== m_act(pe)) begin n_fail++; $display("FAIL frames enable lat%0d cyc%0d: got %b exp %b", L, j, en[i], m_act(pe)); end
                n_checks++; if (fs[i] !== m_fs(pe)) begin n_fail++; $display("FAIL frames frame_start lat%0d cyc%0d: got %b exp %b", L, j, fs[i], m_fs(pe)); end
                n_checks++; if (hsync[i] !== !m_hs(pe)) begin n_fail++; $display("FAIL frames hsync lat%0d cyc%0d: got %b exp %b", L, j, hsync[i], !m_hs(pe)); end
                n_checks++; if (vsync[i] !== !m_vs(pe)) begin n_fail++; $display("FAIL frames vsync lat%0d cyc%0d: got %b exp %b", L, j, vsync[i], !m_vs(pe)); end
                if (m_act(pe)) begin
                    n_checks++; if (fbq[i][L-1] !== 8'(m_addr(pe))) begin n_fail++; $display("FAIL align data_in lat%0d cyc%0d: got %0d exp %0d", L, j, fbq[i][L-1], m_addr(pe)); end
                end
                if (pe >= 0 && pe < 2 * FT) begin
                    n_en[i] += int'(en[i]);
                    n_fs[i] += int'(fs[i]);
                    if (hsync[i] == 1'b0 && prev_hs[i] == 1'b1) n_hs[i]++;
                end
                prev_hs[i] = hsync[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (n_en[i] != 96) begin n_fail++; $display("FAIL frames enable_count inst%0d: got %0d exp 96", i, n_en[i]); end
            n_checks++; if (n_fs[i] != 2)  begin n_fail++; $display("FAIL frames frame_start_count inst%0d: got %0d exp 2", i, n_fs[i]); end
            n_checks++; if (n_hs[i] != 20) begin n_fail++; $display("FAIL frames hsync_pulses inst%0d: got %0d exp 20", i, n_hs[i]); end
        end
        run = 1'b0;
    endtask

    task automatic test_sync_geometry();
        int t_first_en = -1;
        int t_en_fall  = -1;
        int t_hs = -1;
        int hs_len = 0;
        bit hs_end = 1'b0;
        int t_vs = -1;
        int vs_len = 0;
        bit vs_end = 1'b0;
        do_reset();
        run = 1'b1;
        for (int j = 0; j < 400; j++) begin
            tick();
            if (en[1] && t_first_en < 0) t_first_en = j;
            if (!en[1] && t_first_en >= 0 && t_en_fall < 0) t_en_fall = j;
            if (!hsync[1] && t_hs < 0) t_hs = j;
            if (t_hs >= 0 && !hs_end) begin
                if (!hsync[1]) hs_len++; else hs_end = 1'b1;
            end
            if (!vsync[1] && t_vs < 0) t_vs = j;
            if (t_vs >= 0 && !vs_end) begin
                if (!vsync[1]) vs_len++; else vs_end = 1'b1;
            end
        end
        n_checks++; if (t_en_fall - t_first_en != 8)  begin n_fail++; $display("FAIL sync line_width: got %0d exp 8", t_en_fall - t_first_en); end
        n_checks++; if (t_hs - t_en_fall != 2)        begin n_fail++; $display("FAIL sync hsync_front_porch: got %0d exp 2", t_hs - t_en_fall); end
        n_checks++; if (hs_len != 3)                  begin n_fail++; $display("FAIL sync hsync_width: got %0d exp 3", hs_len); end
        n_checks++; if (t_vs - t_first_en != 112)     begin n_fail++; $display("FAIL sync vsync_start: got %0d exp 112", t_vs - t_first_en); end
        n_checks++; if (vs_len != 32)                 begin n_fail++; $display("FAIL sync vsync_width: got %0d exp 32", vs_len); end
        run = 1'b0;
    endtask

    task automatic test_stop_restart();
        int n_en = 0;
        do_reset();
        run = 1'b1;
        for (int j = 0; j <= 170; j++) begin
            tick();
            n_en += int'(en[1]);
            if (j == 159) begin
                n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL stop busy_before_end: got %b exp 1", busy[1]); end
            end
            if (j == 160) begin
                n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL stop busy_after_end: got %b exp 0", busy[1]); end
            end
            if (j == 3 * HT + 5) run = 1'b0;
        end
        n_checks++; if (n_en != 48) begin n_fail++; $display("FAIL stop enable_count: got %0d exp 48", n_en); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({en[i], rd_req[i], fs[i], busy[i]} !== 4'b0000) begin n_fail++; $display("FAIL stop idle_outputs inst%0d: got %b exp 0000", i, {en[i], rd_req[i], fs[i], busy[i]}); end
            n_checks++; if ({hsync[i], vsync[i]} !== 2'b11) begin n_fail++; $display("FAIL stop idle_syncs inst%0d: got %b exp 11", i, {hsync[i], vsync[i]}); end
        end
        run = 1'b1;
        tick();
        n_checks++; if (rd_req[1] !== 1'b0) begin n_fail++; $display("FAIL restart early_rd_req: got %b exp 0", rd_req[1]); end
        n_checks++; if (busy[1] !== 1'b1)   begin n_fail++; $display("FAIL restart busy: got %b exp 1", busy[1]); end
        tick();
        n_checks++; if (rd_req[1] !== 1'b1)   begin n_fail++; $display("FAIL restart rd_req: got %b exp 1", rd_req[1]); end
        n_checks++; if (rd_addr[1] !== 8'd0)  begin n_fail++; $display("FAIL restart rd_addr: got %0d exp 0", rd_addr[1]); end
        run = 1'b0;
    endtask

    task automatic test_last_pixel_stop();
        int n_req_after = 0;
        int n_fs = 0;
        do_reset();
        run = 1'b1;
        for (int j = 0; j <= 170; j++) begin
            tick();
            n_fs += int'(fs[1]);
            if (j >= 161) n_req_after += int'(rd_req[1]);
            if (j == 160) begin
                n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL lastpix busy: got %b exp 0", busy[1]); end
            end
            if (j == 159) run = 1'b0;
        end
        n_checks++; if (n_req_after != 0) begin n_fail++; $display("FAIL lastpix extra_requests: got %0d exp 0", n_req_after); end
        n_checks++; if (n_fs != 1)        begin n_fail++; $display("FAIL lastpix frame_starts: got %0d exp 1", n_fs); end
    endtask

    task automatic test_cancelled_stop();
        int n_req = 0;
        int last_addr = -1;
        do_reset();
        run = 1'b1;
        for (int j = 0; j <= FT + 3; j++) begin
            tick();
            n_checks++; if (rd_req[1] !== m_act(j - 1)) begin n_fail++; $display("FAIL cancel rd_req cyc%0d: got %b exp %b", j, rd_req[1], m_act(j - 1)); end
            if (m_act(j - 1)) begin
                n_checks++; if (rd_addr[1] !== 8'(m_addr(j - 1))) begin n_fail++; $display("FAIL cancel rd_addr cyc%0d: got %0d exp %0d", j, rd_addr[1], m_addr(j - 1)); end
            end
            n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL cancel busy cyc%0d: got %b exp 1", j, busy[1]); end
            if (rd_req[1] && j - 1 < FT) begin
                n_req++;
                last_addr = int'(rd_addr[1]);
            end
            if (j == 4 * HT + 2) run = 1'b0;
            if (j == 4 * HT + 7) run = 1'b1;
        end
        n_checks++; if (n_req != 48)     begin n_fail++; $display("FAIL cancel request_count: got %0d exp 48", n_req); end
        n_checks++; if (last_addr != 47) begin n_fail++; $display("FAIL cancel last_addr: got %0d exp 47", last_addr); end
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        for (int j = 0; j <= 2 * HT + 3; j++) tick();
        n_checks++; if (en[1] !== 1'b1) begin n_fail++; $display("FAIL areset pre_enable: got %b exp 1", en[1]); end
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({en[i], rd_req[i], fs[i], busy[i]} !== 4'b0000) begin n_fail++; $display("FAIL areset outputs inst%0d: got %b exp 0000", i, {en[i], rd_req[i], fs[i], busy[i]}); end
            n_checks++; if ({hsync[i], vsync[i]} !== 2'b11) begin n_fail++; $display("FAIL areset syncs inst%0d: got %b exp 11", i, {hsync[i], vsync[i]}); end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (fs[i] !== (k == lat_of(i) + 2)) begin n_fail++; $display("FAIL areset frame_start lat%0d edge%0d: got %b exp %b", lat_of(i), k, fs[i], (k == lat_of(i) + 2)); end
            end
        end
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        test_reset();
        test_frames();
        test_sync_geometry();
        test_stop_restart();
        test_last_pixel_stop();
        test_cancelled_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
